ipsxe_fft_distributed_delayline_v1_4: RTL and testbench

Multi-lane, run-time-programmable delay line built on distributed RAM, used inside the FFT datapath to align butterfly operands and twiddle streams across stages. It generalises the fixed/dynamic shift register with NUM_CH parallel lanes sharing one write pointer, a per-sample valid tag, and a fill/reload state machine. After reset or a depth change, dout_valid is never asserted for stale RAM contents.

---
 rtl/ipsxe_fft_dl_pkg.sv | 26 ++
 rtl/ipsxe_fft_distributed_sdpram_v1_2.sv | 39 +++
 rtl/ipsxe_fft_distributed_delayline_v1_4.sv | 77 +++++++
 tb/tb_ipsxe_fft_distributed_delayline_v1_4.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/ipsxe_fft_dl_pkg.sv
// Shared definitions for the FFT distributed delay line: state encoding,
// constant-width helper and the depth clamp applied when a new depth is loaded.
package ipsxe_fft_dl_pkg;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // A zero delay is not representable by the ring, so it degrades to one sample.
    function automatic int unsigned clamp_depth(input int unsigned d, input int unsigned max_d);
        if (d == 0) return 1;
        else if (d > max_d) return max_d;
        else return d;
    endfunction

endpackage

// File: rtl/ipsxe_fft_distributed_sdpram_v1_2.sv
// Simple dual-port distributed RAM: synchronous write, asynchronous read,
// with an optional registered read port. Contents are never reset.
module ipsxe_fft_distributed_sdpram_v1_2 #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 17,
    parameter int OUT_REG    = 0
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    localparam int WORDS = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    generate
        if (OUT_REG != 0) begin : g_reg
            logic [DATA_WIDTH-1:0] rd_q;
            // Same-address read and write return the old word.
            always_ff @(posedge clk) begin
                if (rd_en) rd_q <= mem[rd_addr];
            end
            assign rd_data = rd_q;
        end else begin : g_comb
            logic unused_rd_en;
            assign unused_rd_en = rd_en;
            assign rd_data = mem[rd_addr];
        end
    endgenerate

endmodule

// File: rtl/ipsxe_fft_distributed_delayline_v1_4.sv
// Multi-lane programmable delay line over a distributed-RAM ring; outputs are
// masked while the ring refills after reset or a depth change.
module ipsxe_fft_distributed_delayline_v1_4
    import ipsxe_fft_dl_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 1,
    parameter int MAX_DEPTH  = 16,
    parameter int OUT_REG    = 0,
    localparam int AW = (clog2(MAX_DEPTH) > 4) ? clog2(MAX_DEPTH) : 4,
    localparam int DW = clog2(MAX_DEPTH + 1),
    localparam int WW = NUM_CH * DATA_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clken,
    input  logic [WW-1:0] din,
    input  logic          din_valid,
    input  logic [DW-1:0] depth,
    input  logic          depth_load,
    output logic [WW-1:0] dout,
    output logic          dout_valid,
    output logic          filling
);
    state_t        state;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [AW:0]   depth_ext;
    logic [DW-1:0] cur_depth;
    logic [DW:0]   fill_cnt;
    logic [DW:0]   fill_target;
    logic [WW:0]   ram_q;

    // A depth of 2^AW truncates to zero here, so the read hits the word about to be overwritten.
    assign depth_ext   = (AW + 1)'(cur_depth);
    assign rd_addr     = wr_addr - depth_ext[AW-1:0];
    assign fill_target = {1'b0, cur_depth} + (DW + 1)'(OUT_REG) - (DW + 1)'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_FILL;
            cur_depth <= DW'(MAX_DEPTH);
            wr_addr   <= '0;
            fill_cnt  <= '0;
        end else begin
            if (clken) wr_addr <= wr_addr + AW'(1);
            if (depth_load) begin
                cur_depth <= DW'(clamp_depth(32'(depth), MAX_DEPTH));
                fill_cnt  <= '0;
                state     <= ST_FILL;
            end else if (clken && state == ST_FILL) begin
                if (fill_cnt == fill_target) state <= ST_RUN;
                else fill_cnt <= fill_cnt + (DW + 1)'(1);
            end
        end
    end

    ipsxe_fft_distributed_sdpram_v1_2 #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (WW + 1),
        .OUT_REG    (OUT_REG)
    ) u_ram (
        .clk     (clk),
        .wr_en   (clken),
        .wr_addr (wr_addr),
        .wr_data ({din_valid, din}),
        .rd_en   (clken),
        .rd_addr (rd_addr),
        .rd_data (ram_q)
    );

    // Stale or in-flight words never leave the block while filling.
    assign dout       = (state == ST_RUN) ? ram_q[WW-1:0] : '0;
    assign dout_valid = (state == ST_RUN) && ram_q[WW];
    assign filling    = (state == ST_FILL);

endmodule

// File: tb/tb_ipsxe_fft_distributed_delayline_v1_4.sv
// Scoreboard bench: a 4-lane OUT_REG=0 instance and a 1-lane OUT_REG=1 instance
// share one directed stimulus stream; a negedge monitor pops expected outputs.
module tb_ipsxe_fft_distributed_delayline_v1_4;
    localparam int MAXD = 16;

    typedef struct packed {
        logic        fill;
        logic        vld;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clken = 1'b0;
    logic        din_valid = 1'b0;
    logic        depth_load = 1'b0;
    logic [4:0]  depth = '0;
    logic [31:0] din_a = '0;
    logic [15:0] din_b = '0;
    logic [31:0] dout_a;
    logic [15:0] dout_b;
    logic        dv_a, dv_b, fill_a, fill_b;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   n_chk = 0;
    int   n_pass = 0;
    bit   hist_v [0:1023];
    int   cnt = 0;
    int   cur_d = MAXD;
    int   run_a = MAXD;
    int   run_b = MAXD + 1;
    bit [15:0] pat = 16'b1011_0010_1110_0110;

    always #5 clk = ~clk;

    ipsxe_fft_distributed_delayline_v1_4 #(
        .DATA_WIDTH (8), .NUM_CH (4), .MAX_DEPTH (MAXD), .OUT_REG (0)
    ) dut_a (
        .clk (clk), .rst_n (rst_n), .clken (clken), .din (din_a), .din_valid (din_valid),
        .depth (depth), .depth_load (depth_load), .dout (dout_a), .dout_valid (dv_a),
        .filling (fill_a)
    );

    ipsxe_fft_distributed_delayline_v1_4 #(
        .DATA_WIDTH (16), .NUM_CH (1), .MAX_DEPTH (MAXD), .OUT_REG (1)
    ) dut_b (
        .clk (clk), .rst_n (rst_n), .clken (clken), .din (din_b), .din_valid (din_valid),
        .depth (depth), .depth_load (depth_load), .dout (dout_b), .dout_valid (dv_b),
        .filling (fill_b)
    );

    function automatic logic [31:0] lanes(input int k);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = 8'(k + 50 * i);
        return r;
    endfunction

    function automatic int clampd(input int d);
        if (d == 0) return 1;
        if (d > MAXD) return MAXD;
        return d;
    endfunction

    // Expected output of clken cycle t for an instance with the given extra latency.
    function automatic exp_t expect_at(input int t, input int extra, input int run_from, input bit is_a);
        exp_t e;
        int   src;
        e = '0;
        e.fill = 1'b1;
        if (t >= run_from) begin
            src    = t - cur_d - extra;
            e.fill = 1'b0;
            e.vld  = hist_v[src];
            e.data = is_a ? lanes(src) : {16'h0, 16'(src + 'h300)};
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, req);
    endtask

    task automatic cyc(input bit ce, input bit ld = 1'b0, input int ldd = 0, input bit dv = 1'b1);
        @(posedge clk);
        #1;
        clken      = ce;
        depth_load = ld;
        depth      = 5'(ldd);
        din_valid  = dv;
        if (ce) begin
            din_a       = lanes(cnt);
            din_b       = 16'(cnt + 'h300);
            hist_v[cnt] = dv;
            qa.push_back(expect_at(cnt, 0, run_a, 1'b1));
            qb.push_back(expect_at(cnt, 1, run_b, 1'b0));
        end else begin
            din_a = 32'hEEEE_EEEE;
            din_b = 16'hEEEE;
        end
        if (ld) begin
            cur_d = clampd(ldd);
            run_a = cnt + int'(ce) + cur_d;
            run_b = run_a + 1;
        end
        if (ce) cnt++;
    endtask

    always @(negedge clk) begin
        if (rst_n && clken) begin
            if (qa.size() == 0 || qb.size() == 0) begin
                n_chk++;
                $display("FAIL scoreboard_underflow: got %0d/%0d entries required >0", qa.size(), qb.size());
            end else begin
                ea = qa.pop_front();
                eb = qb.pop_front();
                check($sformatf("lane4_out t=%0d", cnt - 1), {fill_a, dv_a, dout_a}, ea);
                check($sformatf("reg_out t=%0d", cnt - 1), {fill_b, dv_b, 16'h0, dout_b}, eb);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_a", {fill_a, dv_a, dout_a}, {1'b1, 1'b0, 32'h0});
        check("reset_b", {fill_b, dv_b, 16'h0, dout_b}, {1'b1, 1'b0, 32'h0});
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Default depth 16 across several write-pointer wraps.
        repeat (40) cyc(1'b1);
        // Depth 5 loaded while clken is low.
        cyc(1'b0, 1'b1, 5);
        repeat (20) cyc(1'b1);
        // Depth 3 with irregular clken.
        cyc(1'b1, 1'b1, 3);
        for (int i = 0; i < 48; i++) cyc(pat[i % 16]);
        // Depth 4 then 8 loaded while running.
        cyc(1'b1, 1'b1, 4);
        repeat (12) cyc(1'b1);
        cyc(1'b1, 1'b1, 8);
        repeat (16) cyc(1'b1);
        // Stored valid tag low for a few samples.
        repeat (3) cyc(1'b1, 1'b0, 0, 1'b0);
        repeat (12) cyc(1'b1);
        // Clamp cases.
        cyc(1'b1, 1'b1, 0);
        repeat (8) cyc(1'b1);
        cyc(1'b1, 1'b1, 31);
        repeat (24) cyc(1'b1);
        cyc(1'b0, 1'b1, 20);
        repeat (20) cyc(1'b1);
        // Reload while still filling.
        cyc(1'b1, 1'b1, 6);
        repeat (3) cyc(1'b1);
        cyc(1'b1, 1'b1, 2);
        repeat (8) cyc(1'b1);
        cyc(1'b1, 1'b1, 16);
        repeat (20) cyc(1'b1);

        // Asynchronous reset in the middle of a running stream.
        @(posedge clk);
        #1 clken = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midreset_a", {fill_a, dv_a, dout_a}, {1'b1, 1'b0, 32'h0});
        check("midreset_b", {fill_b, dv_b, 16'h0, dout_b}, {1'b1, 1'b0, 32'h0});
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cnt   = 0;
        cur_d = MAXD;
        run_a = MAXD;
        run_b = MAXD + 1;
        repeat (25) cyc(1'b1);

        @(posedge clk);
        #1 clken = 1'b0;
        repeat (2) @(posedge clk);
        check("scoreboard_drained", 34'(qa.size() + qb.size()), 34'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
